// File: rtl/seg_mux_counter.sv
// Multi-digit up/down BCD counter with prescaler, parallel load, wrap pulse and a
// time-multiplexed seven-segment scan. Define SEG_HEX_EN for hexadecimal digits.

module seg_digit_cell (
    input  logic [3:0] nib_i,
    input  logic       step_i,
    input  logic       up_i,
    input  logic [3:0] ld_i,
    output logic [3:0] nxt_o,
    output logic       cout_o,
    output logic [3:0] ld_sat_o
);
`ifdef SEG_HEX_EN
    localparam logic [3:0] DMAX = 4'd15;
`else
    localparam logic [3:0] DMAX = 4'd9;
`endif

    // step_i is the carry/borrow arriving from the digit below (constant 1 for digit 0)
    always_comb begin
        nxt_o  = nib_i;
        cout_o = 1'b0;
        if (step_i) begin
            if (up_i) begin
                if (nib_i == DMAX) begin
                    nxt_o  = 4'd0;
                    cout_o = 1'b1;
                end else begin
                    nxt_o = nib_i + 4'd1;
                end
            end else begin
                if (nib_i == 4'd0) begin
                    nxt_o  = DMAX;
                    cout_o = 1'b1;
                end else begin
                    nxt_o = nib_i - 4'd1;
                end
            end
        end
    end

    always_comb begin
`ifdef SEG_HEX_EN
        ld_sat_o = ld_i;
`else
        ld_sat_o = (ld_i > 4'd9) ? 4'd9 : ld_i;
`endif
    end
endmodule

module seg_mux_counter #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 4,
    parameter int SCAN_DIV = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap,
    output logic [DIGITS-1:0]     digitSel,
    output logic [6:0]            segOut
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [DIGITS-1:0][3:0] count_q, count_d;
    logic [DIGITS-1:0][3:0] step_val, ld_nib, ld_sat;
    logic [DIGITS:0]        carry;
    logic [PW-1:0]          presc_q, presc_d;
    logic [SW-1:0]          sdiv_q, sdiv_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   wrap_q, wrap_d;
    logic [DIGITS-1:0]      sel_q, sel_d;
    logic [6:0]             seg_q, seg_d;
    logic                   tick;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b0111111;
            4'h1: s = 7'b0000110;
            4'h2: s = 7'b1011011;
            4'h3: s = 7'b1001111;
            4'h4: s = 7'b1100110;
            4'h5: s = 7'b1101101;
            4'h6: s = 7'b1111101;
            4'h7: s = 7'b0000111;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1101111;
`ifdef SEG_HEX_EN
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b1111100;
            4'hC: s = 7'b0111001;
            4'hD: s = 7'b1011110;
            4'hE: s = 7'b1111001;
            4'hF: s = 7'b1110001;
`endif
            default: s = 7'b1000000;
        endcase
        return s;
    endfunction

    assign ld_nib   = load_val;
    assign carry[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        seg_digit_cell u_cell (
            .nib_i    (count_q[g]),
            .step_i   (carry[g]),
            .up_i     (up),
            .ld_i     (ld_nib[g]),
            .nxt_o    (step_val[g]),
            .cout_o   (carry[g+1]),
            .ld_sat_o (ld_sat[g])
        );
    end

    assign tick = en && (presc_q == PW'(PRESCALE - 1));

    // Load wins over a coincident tick; the tick is simply dropped.
    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = ld_sat;
            presc_d = '0;
        end else if (en) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
                count_d = step_val;
                wrap_d  = carry[DIGITS];
            end
        end
    end

    always_comb begin
        sdiv_d = sdiv_q + SW'(1);
        idx_d  = idx_q;
        if (sdiv_q == SW'(SCAN_DIV - 1)) begin
            sdiv_d = '0;
            idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
        sel_d = DIGITS'(1) << idx_q;
        seg_d = decode(count_q[idx_q]);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
            presc_q <= '0;
            sdiv_q  <= '0;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
            sel_q   <= DIGITS'(1);
            seg_q   <= 7'b0111111;
        end else begin
            count_q <= count_d;
            presc_q <= presc_d;
            sdiv_q  <= sdiv_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
        end
    end

    assign count    = count_q;
    assign wrap     = wrap_q;
    assign digitSel = sel_q;
    assign segOut   = seg_q;
endmodule

// File: tb/tb_seg_mux_counter.sv
// Directed bench for seg_mux_counter with DIGITS=2, PRESCALE=3, SCAN_DIV=2 (BCD build).

module tb_seg_mux_counter;
    logic       clk = 1'b0;
    logic       reset, en, up, load;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       wrap;
    logic [1:0] digitSel;
    logic [6:0] segOut;

    int checks   = 0;
    int failures = 0;

    localparam logic [6:0] S0 = 7'b0111111;
    localparam logic [6:0] S1 = 7'b0000110;
    localparam logic [6:0] S7 = 7'b0000111;

    logic [1:0] sel_exp [8] = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01};

    always #5 clk = ~clk;

    seg_mux_counter #(.DIGITS(2), .PRESCALE(3), .SCAN_DIV(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .wrap     (wrap),
        .digitSel (digitSel),
        .segOut   (segOut)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; load_val = 8'h00;
        step(2);
        chk("rst_count", 32'(count), 32'h00);
        chk("rst_sel", 32'(digitSel), 32'h1);
        chk("rst_seg", 32'(segOut), 32'(S0));
        chk("rst_wrap", 32'(wrap), 32'h0);

        reset = 1'b1;
        step(2);
        chk("cnt_edge2", 32'(count), 32'h00);
        step(1);
        chk("cnt_edge3", 32'(count), 32'h01);
        step(3);
        chk("cnt_edge6", 32'(count), 32'h02);
        en = 1'b0;
        step(10);
        chk("en_off_frozen", 32'(count), 32'h02);

        en = 1'b1; load = 1'b1; load_val = 8'h09;
        step(1);
        load = 1'b0;
        chk("load_09", 32'(count), 32'h09);
        step(3);
        chk("bcd_carry", 32'(count), 32'h10);
        chk("bcd_carry_wrap", 32'(wrap), 32'h0);

        load = 1'b1; load_val = 8'h99;
        step(1);
        load = 1'b0;
        chk("load_99", 32'(count), 32'h99);
        step(3);
        chk("up_wrap_count", 32'(count), 32'h00);
        chk("up_wrap_pulse", 32'(wrap), 32'h1);
        step(1);
        chk("up_wrap_clear", 32'(wrap), 32'h0);

        up = 1'b0; load = 1'b1; load_val = 8'h10;
        step(1);
        load = 1'b0;
        step(3);
        chk("dn_borrow", 32'(count), 32'h09);
        chk("dn_borrow_wrap", 32'(wrap), 32'h0);
        step(27);
        chk("dn_zero", 32'(count), 32'h00);
        chk("dn_zero_wrap", 32'(wrap), 32'h0);
        step(3);
        chk("dn_wrap_count", 32'(count), 32'h99);
        chk("dn_wrap_pulse", 32'(wrap), 32'h1);
        step(1);
        chk("dn_wrap_clear", 32'(wrap), 32'h0);

        up = 1'b1; load = 1'b1; load_val = 8'h00;
        step(1);
        load = 1'b0;
        step(2);
        chk("pre_tick", 32'(count), 32'h00);
        load = 1'b1; load_val = 8'h4F;
        step(1);
        load = 1'b0;
        chk("load_prio_sat", 32'(count), 32'h49);
        chk("load_prio_wrap", 32'(wrap), 32'h0);
        step(2);
        chk("tick_lost", 32'(count), 32'h49);
        step(1);
        chk("next_tick", 32'(count), 32'h50);
        en = 1'b0; load = 1'b1; load_val = 8'hA3;
        step(1);
        load = 1'b0;
        chk("sat_high", 32'(count), 32'h93);

        reset = 1'b0;
        step(1);
        reset = 1'b1; load = 1'b1; load_val = 8'h71;
        step(1);
        load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(1);
            chk($sformatf("scan_sel%0d", k + 2), 32'(digitSel), 32'(sel_exp[k]));
            chk($sformatf("scan_seg%0d", k + 2), 32'(segOut), 32'((sel_exp[k] == 2'b01) ? S1 : S7));
        end

        load = 1'b1; load_val = 8'h37;
        step(1);
        load = 1'b0;
        chk("pre_rst_count", 32'(count), 32'h37);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        chk("mid_rst_count", 32'(count), 32'h00);
        chk("mid_rst_sel", 32'(digitSel), 32'h1);
        chk("mid_rst_wrap", 32'(wrap), 32'h0);
        chk("mid_rst_seg", 32'(segOut), 32'(S0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
